// File: rtl/smooth_pkg.sv
// rtl/smooth_pkg.sv - shared state type and mesh layout constants for the smoothing scheduler
package smooth_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COPY_IN,
    S_AVG_START,
    S_AVG_WAIT_HI,
    S_AVG_WAIT_LO,
    S_COPY_BACK,
    S_DONE
  } sched_state_t;

  // Each vertex is three consecutive words; word 0 is not part of the mesh.
  localparam int         VERTEX_STRIDE = 3;
  localparam int         VERTEX_BASE   = 1;
  localparam logic [3:0] WE_ALL        = 4'b1111;

endpackage

// File: rtl/ram_copy_engine.sv
// rtl/ram_copy_engine.sv - pipelined word copy between the object and result RAMs
module ram_copy_engine
  import smooth_pkg::*;
#(
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic                  dir,
  input  logic [ADDR_WIDTH-1:0] len,
  output logic                  done,
  output logic                  obj_en,
  output logic [3:0]            obj_we,
  output logic [ADDR_WIDTH-1:0] obj_a,
  output logic [31:0]           obj_di,
  input  logic [31:0]           obj_do,
  output logic                  res_en,
  output logic [3:0]            res_we,
  output logic [ADDR_WIDTH-1:0] res_a,
  output logic [31:0]           res_di,
  input  logic [31:0]           res_do
);

  // run is held for the whole copy (dir 0: OBJ->RES, 1: RES->OBJ); cnt is the
  // cycle index within the copy, 0..len, so a copy lasts len+1 cycles.
  logic [ADDR_WIDTH-1:0] cnt;
  logic [ADDR_WIDTH-1:0] rd_a;
  logic [ADDR_WIDTH-1:0] wr_a;
  logic                  rd_on;
  logic                  wr_on;

  // Step through the copy while running; drop back to zero between copies.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (run && (cnt != len)) begin
      cnt <= cnt + ADDR_WIDTH'(1);
    end else begin
      cnt <= '0;
    end
  end

  assign rd_on = cnt != len;
  assign wr_on = cnt != '0;
  assign rd_a  = cnt + ADDR_WIDTH'(VERTEX_BASE);
  assign wr_a  = cnt + ADDR_WIDTH'(VERTEX_BASE) - ADDR_WIDTH'(1);
  assign done  = run && (cnt == len);

  // Read word k in cycle k-1 and write it one cycle later from the source read data.
  always_comb begin
    obj_en = 1'b0;
    obj_we = '0;
    obj_a  = '0;
    obj_di = '0;
    res_en = 1'b0;
    res_we = '0;
    res_a  = '0;
    res_di = '0;
    if (run) begin
      obj_en = 1'b1;
      res_en = 1'b1;
      if (!dir) begin
        obj_a = rd_on ? rd_a : '0;
        if (wr_on) begin
          res_a  = wr_a;
          res_we = WE_ALL;
          res_di = obj_do;
        end
      end else begin
        res_a = rd_on ? rd_a : '0;
        if (wr_on) begin
          obj_a  = wr_a;
          obj_we = WE_ALL;
          obj_di = res_do;
        end
      end
    end
  end

endmodule

// File: rtl/smooth_scheduler.sv
// rtl/smooth_scheduler.sv - sequences averager passes with RAM copies; watchdog under SMOOTH_SCHED_WATCHDOG_EN
module smooth_scheduler
  import smooth_pkg::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int MAX_ITER_W = 8
`ifdef SMOOTH_SCHED_WATCHDOG_EN
  ,
  parameter int WDOG_CYCLES = 65536
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [MAX_ITER_W-1:0] iterations,
  input  logic [31:0]           vertex_count,
  output logic                  busy,
  output logic                  done,
  output logic [MAX_ITER_W-1:0] iter_cnt,
  output logic                  avg_start,
  input  logic                  avg_busy,
  output logic                  sel_avg,
  output logic                  obj_en,
  output logic [3:0]            obj_we,
  output logic [ADDR_WIDTH-1:0] obj_a,
  output logic [31:0]           obj_di,
  input  logic [31:0]           obj_do,
  output logic                  res_en,
  output logic [3:0]            res_we,
  output logic [ADDR_WIDTH-1:0] res_a,
  output logic [31:0]           res_di,
  input  logic [31:0]           res_do,
  output logic                  error
);

  sched_state_t          state;
  sched_state_t          next_state;
  logic [MAX_ITER_W-1:0] iters_q;
  logic [MAX_ITER_W-1:0] iter_cnt_q;
  logic [ADDR_WIDTH-1:0] len_q;
  logic [ADDR_WIDTH-1:0] mesh_len;
  logic                  accept;
  logic                  zero_job;
  logic                  last_pass;
  logic                  copy_run;
  logic                  copy_dir;
  logic                  copy_done;
  logic                  wdog_expired;
  logic                  error_q;

  assign accept    = (state == S_IDLE) && start;
  assign zero_job  = (iterations == '0) || (vertex_count == '0);
  // Only the low address bits of 3*vertex_count matter once truncated.
  assign mesh_len  = vertex_count[ADDR_WIDTH-1:0] * ADDR_WIDTH'(VERTEX_STRIDE);
  assign last_pass = (iter_cnt_q + MAX_ITER_W'(1)) == iters_q;
  assign copy_run  = (state == S_COPY_IN) || (state == S_COPY_BACK);
  assign copy_dir  = state == S_COPY_BACK;
  assign iter_cnt  = iter_cnt_q;
  assign error     = error_q;

`ifdef SMOOTH_SCHED_WATCHDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
  logic [WDOG_W-1:0] wdog_cnt;

  // Count cycles spent waiting on the averager; restart at every pass.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog_cnt <= '0;
    end else if (state == S_AVG_START) begin
      wdog_cnt <= '0;
    end else if ((state == S_AVG_WAIT_HI) || (state == S_AVG_WAIT_LO)) begin
      wdog_cnt <= wdog_cnt + WDOG_W'(1);
    end
  end

  assign wdog_expired = ((state == S_AVG_WAIT_HI) || (state == S_AVG_WAIT_LO)) &&
                        (wdog_cnt == WDOG_W'(WDOG_CYCLES - 1));
`else
  assign wdog_expired = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Job parameters latched on start, pass counter and sticky watchdog flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iters_q    <= '0;
      len_q      <= '0;
      iter_cnt_q <= '0;
      error_q    <= 1'b0;
    end else begin
      if (accept) begin
        iters_q    <= iterations;
        len_q      <= mesh_len;
        iter_cnt_q <= '0;
        error_q    <= 1'b0;
      end
      if ((state == S_COPY_BACK) && copy_done) begin
        iter_cnt_q <= iter_cnt_q + MAX_ITER_W'(1);
      end
      if (wdog_expired) begin
        error_q <= 1'b1;
      end
    end
  end

  // Next-state logic and state-decoded handshake outputs.
  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    avg_start  = 1'b0;
    sel_avg    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          next_state = zero_job ? S_DONE : S_COPY_IN;
        end
      end
      S_COPY_IN: begin
        busy = 1'b1;
        if (copy_done) begin
          next_state = S_AVG_START;
        end
      end
      S_AVG_START: begin
        busy       = 1'b1;
        sel_avg    = 1'b1;
        avg_start  = 1'b1;
        next_state = S_AVG_WAIT_HI;
      end
      S_AVG_WAIT_HI: begin
        busy    = 1'b1;
        sel_avg = 1'b1;
        if (wdog_expired) begin
          next_state = S_DONE;
        end else if (avg_busy) begin
          next_state = S_AVG_WAIT_LO;
        end
      end
      S_AVG_WAIT_LO: begin
        busy    = 1'b1;
        sel_avg = 1'b1;
        if (wdog_expired) begin
          next_state = S_DONE;
        end else if (!avg_busy) begin
          next_state = S_COPY_BACK;
        end
      end
      S_COPY_BACK: begin
        busy = 1'b1;
        if (copy_done) begin
          // OBJ == RES after a copy back, so further passes skip COPY_IN.
          next_state = last_pass ? S_DONE : S_AVG_START;
        end
      end
      S_DONE: begin
        done       = 1'b1;
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  ram_copy_engine #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_copy (
    .clk    (clk),
    .rst    (rst),
    .run    (copy_run),
    .dir    (copy_dir),
    .len    (len_q),
    .done   (copy_done),
    .obj_en (obj_en),
    .obj_we (obj_we),
    .obj_a  (obj_a),
    .obj_di (obj_di),
    .obj_do (obj_do),
    .res_en (res_en),
    .res_we (res_we),
    .res_a  (res_a),
    .res_di (res_di),
    .res_do (res_do)
  );

endmodule
